// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, visible-region flag, delayed
// active-low sync pulses, a once-per-frame tick and a completed-frame counter.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic        r_run;
    logic [9:0]  r_hc;
    logic [9:0]  r_vc;
    logic [15:0] r_frameCount;

    logic w_hLast;
    logic w_vLast;
    logic w_hsRaw;
    logic w_vsRaw;

    assign w_hLast = (r_hc == H_LAST);
    assign w_vLast = (r_vc == V_LAST);

    // The first edge after reset only arms r_run, so (0,0) is held one extra clock.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_run        <= 1'b0;
            r_hc         <= '0;
            r_vc         <= '0;
            r_frameCount <= '0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                if (w_hLast) begin
                    r_hc <= '0;
                    if (w_vLast) begin
                        r_vc         <= '0;
                        r_frameCount <= r_frameCount + 16'd1;
                    end else begin
                        r_vc <= r_vc + 10'd1;
                    end
                end else begin
                    r_hc <= r_hc + 10'd1;
                end
            end
        end
    end

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign frame_count = r_frameCount;
    assign blank       = r_run & (r_hc < H_VIS_END) & (r_vc < V_VIS_END);
    assign frame_tick  = r_run & (r_hc == 10'd0) & (r_vc == V_VIS_END);

    assign w_hsRaw = ~(r_run & (r_hc >= H_SYNC_START) & (r_hc < H_SYNC_END));
    assign w_vsRaw = ~(r_run & (r_vc >= V_SYNC_START) & (r_vc < V_SYNC_END));

    // Sync delay keeps hs/vs aligned with RGB registered by downstream stages.
    generate
        if (PIPE_DELAY == 0) begin : g_noDelay
            assign hs = w_hsRaw;
            assign vs = w_vsRaw;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] r_hsDly;
            logic [PIPE_DELAY-1:0] r_vsDly;

            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    r_hsDly <= '1;
                    r_vsDly <= '1;
                end else begin
                    r_hsDly[0] <= w_hsRaw;
                    r_vsDly[0] <= w_vsRaw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_hsDly[i] <= r_hsDly[i-1];
                        r_vsDly[i] <= r_vsDly[i-1];
                    end
                end
            end

            assign hs = r_hsDly[PIPE_DELAY-1];
            assign vs = r_vsDly[PIPE_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three small-raster instances (sync delay 0, 1, 3)
// checked against a position-from-edge-count reference through a scoreboard queue.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]  drawX [3];
    logic [9:0]  drawY [3];
    logic        blank [3];
    logic        hs    [3];
    logic        vs    [3];
    logic        tick  [3];
    logic [15:0] count [3];

    vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .PIPE_DELAY(0)) dut0 (
        .vga_clk(clk), .reset(reset), .DrawX(drawX[0]), .DrawY(drawY[0]),
        .blank(blank[0]), .hs(hs[0]), .vs(vs[0]), .frame_tick(tick[0]),
        .frame_count(count[0]));

    vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .PIPE_DELAY(1)) dut1 (
        .vga_clk(clk), .reset(reset), .DrawX(drawX[1]), .DrawY(drawY[1]),
        .blank(blank[1]), .hs(hs[1]), .vs(vs[1]), .frame_tick(tick[1]),
        .frame_count(count[1]));

    vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .PIPE_DELAY(3)) dut3 (
        .vga_clk(clk), .reset(reset), .DrawX(drawX[2]), .DrawY(drawY[2]),
        .blank(blank[2]), .hs(hs[2]), .vs(vs[2]), .frame_tick(tick[2]),
        .frame_count(count[2]));

    typedef struct packed {
        int       x;
        int       y;
        logic     blank;
        logic     tick;
        int       count;
        logic [2:0] hs;
        logic [2:0] vs;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   k = 0;
    exp_t sbq[$];
    int   dly[3] = '{0, 1, 3};

    // State after j edges since release; edge 1 only arms the run flag.
    function automatic logic hsRawAt(int j);
        int hc;
        if (j < 1) return 1'b1;
        hc = (j - 1) % HT;
        return !(hc >= HV + HF && hc < HV + HF + HS);
    endfunction

    function automatic logic vsRawAt(int j);
        int vc;
        if (j < 1) return 1'b1;
        vc = ((j - 1) / HT) % VT;
        return !(vc >= VV + VF && vc < VV + VF + VS);
    endfunction

    function automatic exp_t expectAt(int kk);
        exp_t e;
        int p;
        p = (kk < 1) ? 0 : kk - 1;
        e.x     = p % HT;
        e.y     = (p / HT) % VT;
        e.blank = (kk >= 1) && (e.x < HV) && (e.y < VV);
        e.tick  = (kk >= 1) && (e.x == 0) && (e.y == VV);
        e.count = (p / FT) % 65536;
        for (int i = 0; i < 3; i++) begin
            e.hs[i] = hsRawAt(kk - dly[i]);
            e.vs[i] = vsRawAt(kk - dly[i]);
        end
        return e;
    endfunction

    task automatic pushEdge();
        @(posedge clk);
        k++;
        sbq.push_back(expectAt(k));
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (drawX[i] !== 10'd0 || drawY[i] !== 10'd0 || blank[i] !== 1'b0 ||
                    hs[i] !== 1'b1 || vs[i] !== 1'b1 || tick[i] !== 1'b0 || count[i] !== 16'd0) begin
                    errors++;
                    $display("[TB] FAIL reset_state dut%0d pass%0d: got x=%0d y=%0d b=%b hs=%b vs=%b t=%b c=%0d, expected 0 0 0 1 1 0 0",
                             i, pass, drawX[i], drawY[i], blank[i], hs[i], vs[i], tick[i], count[i]);
                end
            end
            reset = 1'b0;
            k = 0;
            #1;
        end
    endtask

    task automatic test_first_line();
        exp_t e;
        repeat (HT + 1) begin
            pushEdge();
            e = sbq.pop_front();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (drawX[i] !== 10'(e.x) || drawY[i] !== 10'(e.y) || blank[i] !== e.blank) begin
                    errors++;
                    $display("[TB] FAIL first_line dut%0d edge%0d: got x=%0d y=%0d b=%b, expected x=%0d y=%0d b=%b",
                             i, k, drawX[i], drawY[i], blank[i], e.x, e.y, e.blank);
                end
            end
        end
    endtask

    task automatic test_sync();
        exp_t e;
        logic prevHs [3];
        logic prevVs [3];
        int   hLow [3];
        int   vLow [3];
        int   ticks [3];
        bit   hSeen [3];
        bit   vSeen [3];
        for (int i = 0; i < 3; i++) begin
            prevHs[i] = hs[i]; prevVs[i] = vs[i];
            hLow[i] = 0; vLow[i] = 0; ticks[i] = 0; hSeen[i] = 0; vSeen[i] = 0;
        end
        repeat (FT) begin
            pushEdge();
            e = sbq.pop_front();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hs[i] !== e.hs[i] || vs[i] !== e.vs[i]) begin
                    errors++;
                    $display("[TB] FAIL sync_level dut%0d edge%0d: got hs=%b vs=%b, expected hs=%b vs=%b",
                             i, k, hs[i], vs[i], e.hs[i], e.vs[i]);
                end
                if (prevHs[i] && !hs[i]) begin
                    checks++;
                    if (drawX[i] !== 10'((HV + HF + dly[i]) % HT)) begin
                        errors++;
                        $display("[TB] FAIL hs_fall_pos dut%0d: got x=%0d, expected x=%0d",
                                 i, drawX[i], (HV + HF + dly[i]) % HT);
                    end
                    hSeen[i] = 1; hLow[i] = 0;
                end
                if (!hs[i]) hLow[i]++;
                if (!prevHs[i] && hs[i] && hSeen[i]) begin
                    checks++;
                    if (hLow[i] != HS) begin
                        errors++;
                        $display("[TB] FAIL hs_width dut%0d: got %0d clocks, expected %0d", i, hLow[i], HS);
                    end
                end
                if (prevVs[i] && !vs[i]) begin
                    checks++;
                    if (drawX[i] !== 10'(dly[i]) || drawY[i] !== 10'(VV + VF)) begin
                        errors++;
                        $display("[TB] FAIL vs_fall_pos dut%0d: got (%0d,%0d), expected (%0d,%0d)",
                                 i, drawX[i], drawY[i], dly[i], VV + VF);
                    end
                    vSeen[i] = 1; vLow[i] = 0;
                end
                if (!vs[i]) vLow[i]++;
                if (!prevVs[i] && vs[i] && vSeen[i]) begin
                    checks++;
                    if (vLow[i] != VS * HT) begin
                        errors++;
                        $display("[TB] FAIL vs_width dut%0d: got %0d clocks, expected %0d", i, vLow[i], VS * HT);
                    end
                end
                if (drawY[i] >= 10'(VV)) begin
                    checks++;
                    if (blank[i] !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL blank_vblank dut%0d y=%0d: got %b, expected 0", i, drawY[i], blank[i]);
                    end
                end
                if (tick[i] === 1'b1) begin
                    ticks[i]++;
                    checks++;
                    if (drawX[i] !== 10'd0 || drawY[i] !== 10'(VV)) begin
                        errors++;
                        $display("[TB] FAIL tick_pos dut%0d: got (%0d,%0d), expected (0,%0d)", i, drawX[i], drawY[i], VV);
                    end
                end
                prevHs[i] = hs[i]; prevVs[i] = vs[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ticks[i] != 1 || !hSeen[i] || !vSeen[i]) begin
                errors++;
                $display("[TB] FAIL frame_events dut%0d: got ticks=%0d hsFall=%0d vsFall=%0d, expected 1 1 1",
                         i, ticks[i], hSeen[i], vSeen[i]);
            end
        end
    endtask

    task automatic test_frames();
        exp_t e;
        int   lastTick = -1;
        int   incs = 0;
        logic [15:0] prevCount;
        prevCount = count[1];
        repeat (3 * FT) begin
            pushEdge();
            e = sbq.pop_front();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (count[i] !== 16'(e.count) || tick[i] !== e.tick || drawY[i] !== 10'(e.y)) begin
                    errors++;
                    $display("[TB] FAIL frame_state dut%0d edge%0d: got c=%0d t=%b y=%0d, expected c=%0d t=%b y=%0d",
                             i, k, count[i], tick[i], drawY[i], e.count, e.tick, e.y);
                end
            end
            if (count[1] !== prevCount) begin
                incs++;
                checks++;
                if (drawX[1] !== 10'd0 || drawY[1] !== 10'd0) begin
                    errors++;
                    $display("[TB] FAIL count_wrap_pos: got (%0d,%0d), expected (0,0)", drawX[1], drawY[1]);
                end
                prevCount = count[1];
            end
            if (tick[1] === 1'b1) begin
                if (lastTick >= 0) begin
                    checks++;
                    if (k - lastTick != FT) begin
                        errors++;
                        $display("[TB] FAIL tick_spacing: got %0d clocks, expected %0d", k - lastTick, FT);
                    end
                end
                lastTick = k;
            end
        end
        checks++;
        if (incs != 3) begin
            errors++;
            $display("[TB] FAIL count_increments: got %0d, expected 3", incs);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        repeat (3 * HT + 5) begin
            pushEdge();
            e = sbq.pop_front();
            checks++;
            if (drawX[0] !== 10'(e.x) || drawY[0] !== 10'(e.y)) begin
                errors++;
                $display("[TB] FAIL pre_reset_pos edge%0d: got (%0d,%0d), expected (%0d,%0d)",
                         k, drawX[0], drawY[0], e.x, e.y);
            end
        end
        #2 reset = 1'b1;
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (drawX[i] !== 10'd0 || drawY[i] !== 10'd0 || blank[i] !== 1'b0 ||
                    hs[i] !== 1'b1 || vs[i] !== 1'b1 || tick[i] !== 1'b0 || count[i] !== 16'd0) begin
                    errors++;
                    $display("[TB] FAIL async_reset dut%0d pass%0d: got x=%0d y=%0d b=%b hs=%b vs=%b t=%b c=%0d, expected 0 0 0 1 1 0 0",
                             i, pass, drawX[i], drawY[i], blank[i], hs[i], vs[i], tick[i], count[i]);
                end
            end
            @(negedge clk);
        end
        reset = 1'b0;
        k = 0;
        sbq.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   edgeN = 0;
        repeat (HT + 2) begin
            pushEdge();
            edgeN++;
            e = sbq.pop_front();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (drawX[i] !== 10'(e.x) || drawY[i] !== 10'(e.y) || blank[i] !== e.blank ||
                    hs[i] !== e.hs[i] || vs[i] !== e.vs[i]) begin
                    errors++;
                    $display("[TB] FAIL restart dut%0d edge%0d: got x=%0d y=%0d b=%b hs=%b vs=%b, expected x=%0d y=%0d b=%b hs=%b vs=%b",
                             i, k, drawX[i], drawY[i], blank[i], hs[i], vs[i], e.x, e.y, e.blank, e.hs[i], e.vs[i]);
                end
            end
            if (edgeN <= 2) begin
                checks++;
                if (drawX[1] !== 10'(edgeN - 1) || blank[1] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL restart_hold edge%0d: got x=%0d b=%b, expected x=%0d b=1",
                             edgeN, drawX[1], blank[1], edgeN - 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_sync();
        test_frames();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
